// File: rtl/tile_color_pkg.sv
// Shared types, palette constants and palette lookup for the tile colour animator.
package tile_color_pkg;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb8_t;

    typedef enum logic [1:0] {
        IDLE,
        FADE,
        FLASH
    } anim_state_t;

    localparam rgb8_t PAL_0     = 24'hE6E6E6;
    localparam rgb8_t PAL_4     = 24'hFFC4C4;
    localparam rgb8_t PAL_8     = 24'hFFE8C4;
    localparam rgb8_t PAL_16    = 24'hFFF7C4;
    localparam rgb8_t PAL_32    = 24'hC4FFC4;
    localparam rgb8_t PAL_64    = 24'hC4FFFF;
    localparam rgb8_t PAL_128   = 24'hC4C4FF;
    localparam rgb8_t PAL_256   = 24'hFFC4FF;
    localparam rgb8_t PAL_512   = 24'hFFD1DC;
    localparam rgb8_t PAL_1024  = 24'hFFDEAD;
    localparam rgb8_t PAL_2048  = 24'hD5B8B8;
    localparam rgb8_t PAL_TEXT  = 24'h000000;
    localparam rgb8_t PAL_OTHER = 24'hFFFFFF;

    // Value 3 is the text marker; unknown values fall back to white.
    function automatic rgb8_t palette_rgb(input logic [31:0] v);
        rgb8_t c;
        case (v)
            32'd0:    c = PAL_0;
            32'd3:    c = PAL_TEXT;
            32'd4:    c = PAL_4;
            32'd8:    c = PAL_8;
            32'd16:   c = PAL_16;
            32'd32:   c = PAL_32;
            32'd64:   c = PAL_64;
            32'd128:  c = PAL_128;
            32'd256:  c = PAL_256;
            32'd512:  c = PAL_512;
            32'd1024: c = PAL_1024;
            32'd2048: c = PAL_2048;
            default:  c = PAL_OTHER;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/color_lerp.sv
// Combinational single-channel interpolator: start + floor((target - start) * step / 2**FADE_LOG2).
module color_lerp #(
    parameter int unsigned COLOR_W   = 8,
    parameter int unsigned FADE_LOG2 = 3
) (
    input  logic [COLOR_W-1:0] start,
    input  logic [COLOR_W-1:0] target,
    input  logic [FADE_LOG2:0] step,
    output logic [COLOR_W-1:0] mix_c
);

    localparam int unsigned AW = COLOR_W + FADE_LOG2 + 2;

    logic signed [AW-1:0] diff;
    logic signed [AW-1:0] scaled;
    logic signed [AW-1:0] sum;

    always_comb begin
        diff   = signed'(AW'(target)) - signed'(AW'(start));
        scaled = (diff * signed'(AW'(step))) >>> FADE_LOG2;
        sum    = signed'(AW'(start)) + scaled;
        mix_c  = COLOR_W'(sum);
    end

endmodule

// File: rtl/tile_color_animator.sv
// Per-tile colour animator: palette lookup with frame-stepped fades and a merge flash.
module tile_color_animator
    import tile_color_pkg::*;
#(
    parameter int unsigned VAL_W        = 12,
    parameter int unsigned COLOR_W      = 8,
    parameter int unsigned FADE_LOG2    = 3,
    parameter int unsigned FLASH_FRAMES = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frame_tick,
    input  logic [VAL_W-1:0]   value,
    input  logic               merge_pulse,
    output logic [COLOR_W-1:0] r,
    output logic [COLOR_W-1:0] g,
    output logic [COLOR_W-1:0] b,
    output logic               busy
);

    localparam int unsigned STEP_W = FADE_LOG2 + 1;
    localparam logic [STEP_W-1:0] STEP_END  = STEP_W'(1 << FADE_LOG2);
    localparam logic [7:0]        FLASH_END = 8'(FLASH_FRAMES);

    typedef logic [2:0][COLOR_W-1:0] rgb_t;

    function automatic rgb_t to_cw(input rgb8_t c);
        return {c.r[7 -: COLOR_W], c.g[7 -: COLOR_W], c.b[7 -: COLOR_W]};
    endfunction

    anim_state_t       state_q, state_n;
    rgb_t              out_q, out_n;
    rgb_t              start_q, start_n;
    rgb_t              target_q, target_n;
    rgb_t              lerp_c;
    logic [VAL_W-1:0]  prev_q, prev_n;
    logic [STEP_W-1:0] step_q, step_n, step_inc;
    logic [7:0]        flash_q, flash_n, flash_inc;
    logic              busy_q;
    logic              change;

    assign step_inc  = step_q + STEP_W'(1);
    assign flash_inc = flash_q + 8'd1;

    for (genvar ch = 0; ch < 3; ch++) begin : g_lerp
        color_lerp #(
            .COLOR_W   (COLOR_W),
            .FADE_LOG2 (FADE_LOG2)
        ) u_lerp (
            .start  (start_q[ch]),
            .target (target_q[ch]),
            .step   (step_inc),
            .mix_c  (lerp_c[ch])
        );
    end

    // Priority: merge, then text snap, then change restart, then frame advance.
    always_comb begin
        state_n  = state_q;
        out_n    = out_q;
        start_n  = start_q;
        step_n   = step_q;
        flash_n  = flash_q;
        prev_n   = value;
        target_n = to_cw(palette_rgb(32'(value)));
        change   = (value != prev_q);

        if (merge_pulse) begin
            state_n = FLASH;
            flash_n = '0;
            out_n   = '1;
        end else if (change && (value == VAL_W'(3))) begin
            state_n = IDLE;
            out_n   = '0;
            step_n  = '0;
            flash_n = '0;
        end else if (change && (state_q != FLASH)) begin
            state_n = FADE;
            start_n = out_q;
            step_n  = '0;
        end else if (frame_tick) begin
            case (state_q)
                FADE: begin
                    step_n = step_inc;
                    out_n  = lerp_c;
                    if (step_inc == STEP_END) begin
                        state_n = IDLE;
                    end
                end
                FLASH: begin
                    flash_n = flash_inc;
                    if (flash_inc == FLASH_END) begin
                        state_n = FADE;
                        start_n = '1;
                        step_n  = '0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            busy_q   <= 1'b0;
            out_q    <= to_cw(PAL_0);
            start_q  <= to_cw(PAL_0);
            target_q <= to_cw(PAL_0);
            prev_q   <= '0;
            step_q   <= '0;
            flash_q  <= '0;
        end else begin
            state_q  <= state_n;
            busy_q   <= (state_n != IDLE);
            out_q    <= out_n;
            start_q  <= start_n;
            target_q <= target_n;
            prev_q   <= prev_n;
            step_q   <= step_n;
            flash_q  <= flash_n;
        end
    end

    assign r    = out_q[2];
    assign g    = out_q[1];
    assign b    = out_q[0];
    assign busy = busy_q;

endmodule
